// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - register write-back FIFO draining into registers_bank, with forwarding lookups
module writeback_queue #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_WIDTH-1:0]   in_sel,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    rf_we,
   output logic [ADDR_WIDTH-1:0]   rf_sel,
   output logic [DATA_WIDTH-1:0]   rf_data,
   input  logic [ADDR_WIDTH-1:0]   fwd_sel_a,
   output logic                    fwd_hit_a,
   output logic [DATA_WIDTH-1:0]   fwd_data_a,
   input  logic [ADDR_WIDTH-1:0]   fwd_sel_b,
   output logic                    fwd_hit_b,
   output logic [DATA_WIDTH-1:0]   fwd_data_b,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] r_sel_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  w_push;
   logic                  w_pop;
   logic [DATA_WIDTH:0]   w_fwd_a;
   logic [DATA_WIDTH:0]   w_fwd_b;

   // Scan oldest to youngest so the last match (youngest entry) wins.
   function automatic logic [DATA_WIDTH:0] fwd_lookup(input logic [ADDR_WIDTH-1:0] sel);
      logic [DATA_WIDTH:0] res;
      logic [PTR_W-1:0]    idx;
      res = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = r_rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < r_count) && (sel != '0) && (r_sel_mem[idx] == sel))
            res = {1'b1, r_data_mem[idx]};
      end
      return res;
   endfunction

   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign in_ready = !reset && (r_count < CNT_W'(DEPTH));
   assign w_push   = in_valid && in_ready && (in_sel != '0);
   assign w_pop    = !empty;

   assign rf_we   = w_pop;
   assign rf_sel  = w_pop ? r_sel_mem[r_rd_ptr]  : '0;
   assign rf_data = w_pop ? r_data_mem[r_rd_ptr] : '0;

   always_comb begin
      w_fwd_a = fwd_lookup(fwd_sel_a);
      w_fwd_b = fwd_lookup(fwd_sel_b);
   end

   assign fwd_hit_a  = w_fwd_a[DATA_WIDTH];
   assign fwd_data_a = w_fwd_a[DATA_WIDTH-1:0];
   assign fwd_hit_b  = w_fwd_b[DATA_WIDTH];
   assign fwd_data_b = w_fwd_b[DATA_WIDTH-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Entry storage is not reset; only occupied slots are ever observed.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_sel_mem[r_wr_ptr]  <= in_sel;
         r_data_mem[r_wr_ptr] <= in_data;
      end
   end

endmodule
